fp_divider: RTL and testbench
=============================

# fp_divider

Sequential signed fixed-point divider in the same Q format as the fully-connected datapath multiplier: SIZE-bit two's-complement operands, PRECISION fractional bits. It computes dividend / divisor with a restoring shift-subtract algorithm, one quotient bit per cycle. Results are truncated toward zero and saturate with an overflow flag. It sits beside the multiplier in the FC layer and serves normalisation and scaling steps. It uses a valid/ready handshake on both input and output.

## Interface
- SIZE, 16, operand/result width in bits (two's complement)
- PRECISION, 11, fractional bits (Q(SIZE-PRECISION).PRECISION)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  divider idle and able to accept
- dividend  in  SIZE  signed Q operand
- divisor  in  SIZE  signed Q operand
- out_valid  out  1  result registered and stable
- out_ready  in  1  consumer takes result
- quotient  out  SIZE  signed Q result
- overflow  out  1  true result outside [-2^(SIZE-1), 2^(SIZE-1)-1] LSBs; quotient saturated
- div_by_zero  out  1  divisor was 0; quotient saturated

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. Accept when in_valid && in_ready.
  - On accept, latch sign = dividend[MSB]^divisor[MSB].
  - Latch |dividend| (SIZE bits unsigned, so -2^(SIZE-1) is exact) as numerator N = |dividend| << PRECISION, width SIZE+PRECISION.
  - Latch |divisor| (SIZE bits).
  - Clear the remainder (SIZE+1 bits) and the iteration counter.
  - Next state is CALC.
- Divisor == 0 at accept: bypass CALC and go straight to DONE.
  - div_by_zero=1, overflow=0.
  - quotient = 0x7FFF-equivalent (2^(SIZE-1)-1) if dividend >= 0, else -2^(SIZE-1).
- CALC: each cycle:
  - shift the remainder left by 1, bringing in the MSB of N;
  - shift N left by 1;
  - if remainder >= |divisor|, subtract |divisor| and shift 1 into the quotient register (SIZE+PRECISION bits); otherwise shift 0 into it.
  - Exactly SIZE+PRECISION iterations run (27 at defaults). After the last iteration, go to FIX.
- FIX: one cycle. Apply sign to the magnitude Q and saturate:
  - positive result with Q > 2^(SIZE-1)-1: quotient = 2^(SIZE-1)-1, overflow=1;
  - negative result with Q > 2^(SIZE-1): quotient = -2^(SIZE-1), overflow=1;
  - otherwise quotient = ±Q[SIZE-1:0], overflow=0.
  - Register the outputs; next state is DONE.
- DONE: out_valid=1; quotient and flags held stable. On out_valid && out_ready, go to IDLE.
- Rounding: truncation toward zero; the remainder is discarded.
- Zero dividend gives quotient 0 with no flags.

## Timing
- Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, quotient=0, overflow=0, div_by_zero=0, internal registers 0.
- Reset mid-CALC/FIX/DONE: the operation is aborted, nothing is emitted, and the pending result is lost.
- Latency, normal case: accept edge E0; CALC at edges E1..E(SIZE+PRECISION); FIX at E(SIZE+PRECISION+1).
  - out_valid is high in the cycle after E(SIZE+PRECISION+1), i.e. 28 cycles after accept at defaults.
- Latency, divide-by-zero: out_valid is high in the cycle after E0.
- in_ready is 0 in CALC, FIX and DONE. in_valid is ignored while busy; operands are sampled only at the accept edge.
- out_ready is ignored unless out_valid=1. A held-off consumer stalls the block in DONE indefinitely with outputs frozen.
- Handoff on the out handshake edge:
  - out_valid drops and in_ready rises.
  - There is no same-edge accept in DONE; the next accept is earliest one cycle later.
  - Throughput: one divide per SIZE+PRECISION+3 cycles.
- Flags are only meaningful while out_valid=1. They are cleared at the next accept.

## Structure
- Shared package fp_pkg:
  - default SIZE/PRECISION localparams;
  - Q_MAX = 2^(SIZE-1)-1 and Q_MIN = -2^(SIZE-1) constants;
  - state enum {IDLE, CALC, FIX, DONE}.
- The multiplier reuses fp_pkg for its constants.
- One combinational sub-module fp_sign_saturate (magnitude, sign → quotient, overflow). It is reusable later for multiplier saturation.
- The counter is $clog2(SIZE+PRECISION+1) bits wide.

## Test plan
Defaults SIZE=16, PRECISION=11; values in hex.
- Basic: 3.0/2.0 (0x1800/0x1000) → quotient 0x0C00, flags 0. out_valid exactly 28 cycles after accept.
- Truncation and sign: 1/3 (0x0800/0x1800) → 0x02AA. -1/3 (0xF800/0x1800) → 0xFD56. -1/4 (0xF800/0x2000) → 0xFE00.
- Saturation:
  - 15.0/0.25 (0x7800/0x0200) → 0x7FFF, overflow=1.
  - -16/1 (0x8000/0x0800) → 0x8000, overflow=0.
  - -16/-1 (0x8000/0xF800) → 0x7FFF, overflow=1.
- Divide-by-zero: 0x0800/0 → 0x7FFF, div_by_zero=1, out_valid next cycle. 0xF000/0 → 0x8000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs stable and in_ready=0. Pulse in_valid with new operands during CALC → ignored, result unchanged.
- Reset: assert rst at CALC iteration 10 → out_valid and in_ready drop/rise immediately without waiting for a clock. The next divide, 6.0/3.0, returns 0x1000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared fixed-point constants and divider state encoding for the FC datapath.
// Used by the divider and the multiplier so both agree on the Q format.
package fp_pkg;

  localparam int FP_SIZE      = 16;
  localparam int FP_PRECISION = 11;

  localparam logic [FP_SIZE-1:0] Q_MAX = {1'b0, {(FP_SIZE-1){1'b1}}};
  localparam logic [FP_SIZE-1:0] Q_MIN = {1'b1, {(FP_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/fp_divider_if.sv
// Operand/result handshake bundle for the fixed-point divider.
// The slave side is the divider; the master side is the requester/consumer.
interface fp_divider_if #(
  parameter int SIZE = fp_pkg::FP_SIZE
) ();

  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] dividend;
  logic [SIZE-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] quotient;
  logic            overflow;
  logic            div_by_zero;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, overflow, div_by_zero
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, overflow, div_by_zero
  );

endinterface

// File: rtl/fp_sign_saturate.sv
// Applies a sign to an unsigned magnitude and clamps it to the signed SIZE-bit range.
// Purely combinational; shared with the multiplier's saturation path.
module fp_sign_saturate
  import fp_pkg::*;
#(
  parameter int SIZE = FP_SIZE,
  parameter int MW   = FP_SIZE + FP_PRECISION
) (
  input  logic [MW-1:0]   i_mag,
  input  logic            i_neg,
  output logic [SIZE-1:0] o_q,
  output logic            o_ovf
);

  localparam logic [MW-1:0]   POS_LIM = (MW'(1) << (SIZE-1)) - MW'(1);
  localparam logic [MW-1:0]   NEG_LIM = MW'(1) << (SIZE-1);
  localparam logic [SIZE-1:0] W_MAX   = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic [SIZE-1:0] W_MIN   = {1'b1, {(SIZE-1){1'b0}}};

  // The negative side can represent one more LSB than the positive side.
  always_comb begin
    o_q   = i_mag[SIZE-1:0];
    o_ovf = 1'b0;
    if (i_neg) begin
      if (i_mag > NEG_LIM) begin
        o_q   = W_MIN;
        o_ovf = 1'b1;
      end else begin
        o_q = -i_mag[SIZE-1:0];
      end
    end else if (i_mag > POS_LIM) begin
      o_q   = W_MAX;
      o_ovf = 1'b1;
    end
  end

endmodule

// File: rtl/fp_divider.sv
// Signed Q-format restoring divider, one quotient bit per cycle, truncating toward zero.
// Result appears SIZE+PRECISION+1 edges after accept (next cycle on divide-by-zero).
module fp_divider
  import fp_pkg::*;
#(
  parameter int SIZE      = FP_SIZE,
  parameter int PRECISION = FP_PRECISION
) (
  input  logic         clk,
  input  logic         rst,
  fp_divider_if.slave  div_if
);

  localparam int             NW   = SIZE + PRECISION;
  localparam int             CW   = $clog2(NW + 1);
  localparam logic [CW-1:0]  LAST = CW'(NW - 1);
  localparam logic [SIZE-1:0] W_MAX = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic [SIZE-1:0] W_MIN = {1'b1, {(SIZE-1){1'b0}}};

  div_state_t      r_state;
  div_state_t      w_state_nxt;
  logic            r_sign;
  logic [NW-1:0]   r_num;
  logic [NW-1:0]   r_q;
  logic [SIZE-1:0] r_dvs;
  logic [SIZE:0]   r_rem;
  logic [CW-1:0]   r_cnt;
  logic [SIZE-1:0] r_quot;
  logic            r_ovf;
  logic            r_dbz;

  logic [SIZE-1:0] w_dvd_mag;
  logic [SIZE-1:0] w_dvs_mag;
  logic            w_dvs_zero;
  logic [SIZE:0]   w_rem_sh;
  logic [SIZE:0]   w_rem_sub;
  logic            w_ge;
  logic [SIZE-1:0] w_sat_q;
  logic            w_sat_ovf;

  // Unsigned magnitudes: -2^(SIZE-1) negates to itself, which is exact as unsigned.
  assign w_dvd_mag  = div_if.dividend[SIZE-1] ? -div_if.dividend : div_if.dividend;
  assign w_dvs_mag  = div_if.divisor[SIZE-1]  ? -div_if.divisor  : div_if.divisor;
  assign w_dvs_zero = (div_if.divisor == '0);

  assign w_rem_sh  = (r_rem << 1) | {{SIZE{1'b0}}, r_num[NW-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_sub = w_rem_sh - {1'b0, r_dvs};

  fp_sign_saturate #(
    .SIZE (SIZE),
    .MW   (NW)
  ) u_sat (
    .i_mag (r_q),
    .i_neg (r_sign),
    .o_q   (w_sat_q),
    .o_ovf (w_sat_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (div_if.in_valid) begin
          w_state_nxt = w_dvs_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_cnt == LAST) begin
          w_state_nxt = FIX;
        end
      end
      FIX:  w_state_nxt = DONE;
      DONE: begin
        if (div_if.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign <= 1'b0;
      r_num  <= '0;
      r_q    <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_ovf  <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (div_if.in_valid) begin
            r_sign <= div_if.dividend[SIZE-1] ^ div_if.divisor[SIZE-1];
            r_num  <= {w_dvd_mag, {PRECISION{1'b0}}};
            r_dvs  <= w_dvs_mag;
            r_rem  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_dbz  <= w_dvs_zero;
            if (w_dvs_zero) begin
              r_quot <= div_if.dividend[SIZE-1] ? W_MIN : W_MAX;
            end
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_rem_sub : w_rem_sh;
          r_num <= {r_num[NW-2:0], 1'b0};
          r_q   <= {r_q[NW-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_quot <= w_sat_q;
          r_ovf  <= w_sat_ovf;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decode straight from state so reset takes effect without a clock.
  assign div_if.in_ready    = (r_state == IDLE);
  assign div_if.out_valid   = (r_state == DONE);
  assign div_if.quotient    = r_quot;
  assign div_if.overflow    = r_ovf;
  assign div_if.div_by_zero = r_dbz;

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed Q-format vectors, saturation,
// divide-by-zero, backpressure, mid-operation reset and random back-to-back traffic.
module tb_fp_divider;

  typedef struct {
    logic [15:0] q;
    logic        ovf;
    logic        dbz;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  exp_t sb[$];

  fp_divider_if dif ();

  fp_divider dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division of the Q-scaled dividend, truncating toward zero.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint sa;
    longint sb_v;
    longint qv;
    logic [63:0] qbits;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    if (sb_v == 0) begin
      e.dbz = 1'b1;
      e.q   = (sa < 0) ? 16'h8000 : 16'h7FFF;
    end else begin
      qv = (sa * 2048) / sb_v;
      qbits = qv;
      if (qv > 32767) begin
        e.q = 16'h7FFF; e.ovf = 1'b1;
      end else if (qv < -32768) begin
        e.q = 16'h8000; e.ovf = 1'b1;
      end else begin
        e.q = qbits[15:0];
      end
    end
    return e;
  endfunction

  task automatic push_exp(input logic [15:0] q, input logic ovf, input logic dbz);
    exp_t e;
    e.q = q; e.ovf = ovf; e.dbz = dbz;
    sb.push_back(e);
  endtask

  // Accepts one operand pair and returns edges from accept until out_valid (100 = timeout).
  task automatic start_div(input logic [15:0] a, input logic [15:0] b, output int lat);
    int guard;
    guard = 0;
    while (!dif.in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    dif.in_valid = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    lat = 0;
    while (!dif.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic finish_div(input string name);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: result present but scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    if (dif.quotient !== e.q) begin
      n_err++;
      $display("FAIL %s quotient: got %h want %h", name, dif.quotient, e.q);
    end
    n_vec++;
    if (dif.overflow !== e.ovf) begin
      n_err++;
      $display("FAIL %s overflow: got %b want %b", name, dif.overflow, e.ovf);
    end
    n_vec++;
    if (dif.div_by_zero !== e.dbz) begin
      n_err++;
      $display("FAIL %s div_by_zero: got %b want %b", name, dif.div_by_zero, e.dbz);
    end
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    n_vec++;
    if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s handoff: out_valid=%b in_ready=%b want 0/1", name, dif.out_valid, dif.in_ready);
    end
  endtask

  task automatic run_vec(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q, input logic ovf, input logic dbz);
    int lat;
    int want_lat;
    want_lat = dbz ? 0 : 28;
    push_exp(q, ovf, dbz);
    start_div(a, b, lat);
    n_vec++;
    if (lat != want_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, want_lat);
    end
    finish_div(name);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0 || dif.quotient !== 16'h0 ||
        dif.overflow !== 1'b0 || dif.div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset: rdy=%b vld=%b q=%h ovf=%b dbz=%b want 1/0/0000/0/0",
               dif.in_ready, dif.out_valid, dif.quotient, dif.overflow, dif.div_by_zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    run_vec("basic_3_div_2", 16'h1800, 16'h1000, 16'h0C00, 1'b0, 1'b0);
    run_vec("zero_dividend", 16'h0000, 16'h1800, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_sign_trunc;
    run_vec("one_third",      16'h0800, 16'h1800, 16'h02AA, 1'b0, 1'b0);
    run_vec("neg_one_third",  16'hF800, 16'h1800, 16'hFD56, 1'b0, 1'b0);
    run_vec("neg_quarter",    16'hF800, 16'h2000, 16'hFE00, 1'b0, 1'b0);
  endtask

  task automatic test_saturate;
    run_vec("sat_pos",        16'h7800, 16'h0200, 16'h7FFF, 1'b1, 1'b0);
    run_vec("min_div_one",    16'h8000, 16'h0800, 16'h8000, 1'b0, 1'b0);
    run_vec("min_div_negone", 16'h8000, 16'hF800, 16'h7FFF, 1'b1, 1'b0);
  endtask

  task automatic test_div_zero;
    run_vec("dbz_pos", 16'h0800, 16'h0000, 16'h7FFF, 1'b0, 1'b1);
    run_vec("dbz_neg", 16'hF000, 16'h0000, 16'h8000, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure;
    int lat;
    bit stable;
    push_exp(16'h02AA, 1'b0, 1'b0);
    dif.in_valid = 1'b1; dif.dividend = 16'h0800; dif.divisor = 16'h1800;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    dif.in_valid = 1'b1; dif.dividend = 16'h7000; dif.divisor = 16'h0100;
    n_vec++;
    if (dif.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL busy_in_ready: got %b want 0", dif.in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    lat = 7;
    while (!dif.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    n_vec++;
    if (lat != 28) begin
      n_err++;
      $display("FAIL bp_latency: got %0d want 28", lat);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (dif.out_valid !== 1'b1 || dif.in_ready !== 1'b0 || dif.quotient !== 16'h02AA ||
          dif.overflow !== 1'b0 || dif.div_by_zero !== 1'b0)
        stable = 1'b0;
    end
    n_vec++;
    if (!stable) begin
      n_err++;
      $display("FAIL bp_hold: outputs moved while stalled, q=%h vld=%b rdy=%b want 02aa/1/0",
               dif.quotient, dif.out_valid, dif.in_ready);
    end
    finish_div("bp_result");
  endtask

  task automatic test_reset_mid;
    dif.in_valid = 1'b1; dif.dividend = 16'h1800; dif.divisor = 16'h1000;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1 || dif.quotient !== 16'h0) begin
      n_err++;
      $display("FAIL async_reset: vld=%b rdy=%b q=%h want 0/1/0000",
               dif.out_valid, dif.in_ready, dif.quotient);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (dif.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_abort: aborted result emitted, vld=%b want 0", dif.out_valid);
    end
    run_vec("after_reset_6_div_3", 16'h3000, 16'h1800, 16'h1000, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [15:0] a;
    logic [15:0] b;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom);
      b = (i % 4 == 3) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if (i == 5) b = 16'h0000;
      e = model(a, b);
      run_vec("random", a, b, e.q, e.ovf, e.dbz);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    dif.in_valid  = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.out_ready = 1'b0;
    test_reset;
    test_basic;
    test_sign_trunc;
    test_saturate;
    test_div_zero;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
